// File: rtl/sqrt2_pkg.sv
// sqrt2_pkg: shared FSM states, FP16 constants and flag bit indices for the sqrt2 sequencer
package sqrt2_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, WAIT, RELEASE} state_t;
  localparam logic [15:0] QNAN16 = 16'h7E00;
  localparam logic [15:0] NEG_QNAN16 = 16'hFE00;
  localparam int FLAG_NAN = 2;
  localparam int FLAG_PINF = 1;
  localparam int FLAG_NINF = 0;
endpackage

// File: rtl/sqrt2_op_fifo.sv
// sqrt2_op_fifo: synchronous operand queue; a full queue refuses pushes even when popped in the same cycle
module sqrt2_op_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  assign count = cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/sqrt2_sequencer.sv
// sqrt2_sequencer: queues FP16 operands, runs the sqrt2 shared-bus handshake and
// presents each result (or a timeout QNaN) on a valid/ready output stream
module sqrt2_sequencer
  import sqrt2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT = 32
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [2:0]  out_flags,
  output logic        out_timeout,
  output logic        busy,
  inout  wire  [15:0] IO_DATA,
  output logic        SQ_ENABLE,
  input  logic        SQ_RESULT,
  input  logic        SQ_IS_NAN,
  input  logic        SQ_IS_PINF,
  input  logic        SQ_IS_NINF
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  state_t state;
  logic [CW-1:0] wait_cnt;
  logic [15:0] op_reg, head;
  logic [2:0] sq_flags;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic oe, full, empty, push, pop, slot_free;
  assign sq_flags[FLAG_NAN] = SQ_IS_NAN;
  assign sq_flags[FLAG_PINF] = SQ_IS_PINF;
  assign sq_flags[FLAG_NINF] = SQ_IS_NINF;
  assign slot_free = !out_valid || out_ready;
  assign pop = state == IDLE && !empty && slot_free;
  assign push = in_valid && !full;
  assign in_ready = !full;
  assign busy = state != IDLE || fifo_count != '0;
  assign IO_DATA = oe ? op_reg : 'z;
  sqrt2_op_fifo #(.DEPTH(FIFO_DEPTH), .W(16)) u_fifo (
    .clk(CLK),
    .rst(RESET),
    .push(push),
    .pop(pop),
    .din(in_data),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(fifo_count)
  );
  // a capture later in this block overrides the handshake clear of the same cycle
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      SQ_ENABLE <= 1'b0;
      oe <= 1'b0;
      wait_cnt <= '0;
      op_reg <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_flags <= '0;
      out_timeout <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_data <= '0;
        out_flags <= '0;
        out_timeout <= 1'b0;
      end
      case (state)
        IDLE: if (pop) begin
          op_reg <= head;
          SQ_ENABLE <= 1'b1;
          oe <= 1'b1;
          state <= DRIVE;
        end
        DRIVE: begin
          oe <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (SQ_RESULT || wait_cnt == LAST) begin
            out_valid <= 1'b1;
            out_data <= SQ_RESULT ? IO_DATA : QNAN16;
            out_flags <= SQ_RESULT ? sq_flags : 3'b000;
            out_timeout <= !SQ_RESULT;
            SQ_ENABLE <= 1'b0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          wait_cnt <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
